alu_cmd_sequencer: RTL



---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_cmd_fifo.sv | 81 ++++++++
 rtl/alu_cmd_sequencer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer.
// Holds the datapath widths, the ALU mode encodings, the sequencer state
// type and the command record that travels through the command FIFO.
package alu_pkg;

    localparam int OPND_W    = 4;
    localparam int RES_W     = 9;
    localparam int MODE_W    = 2;
    // Widest user tag a command record can carry. Narrower tags are
    // zero-extended into this field and truncated again at the result side.
    localparam int TAG_MAX_W = 8;

    localparam logic [MODE_W-1:0] MODE_ADD = 2'b00;
    localparam logic [MODE_W-1:0] MODE_SUB = 2'b01;
    localparam logic [MODE_W-1:0] MODE_MUL = 2'b10;
    localparam logic [MODE_W-1:0] MODE_MAC = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic [MODE_W-1:0]    mode;
        logic [OPND_W-1:0]    a;
        logic [OPND_W-1:0]    b;
        logic [OPND_W-1:0]    x;
        logic [TAG_MAX_W-1:0] tag;
    } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO for the ALU sequencer.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   push, push_data       write request and entry (ignored while full)
//   pop                   read request (ignored while empty)
//   head                  entry at the read pointer, valid while !empty
//   full, empty, level    occupancy status
// The head entry is read combinationally so the sequencer can pop it and
// load its operand registers on the same edge; the storage is tiny, so it
// maps to distributed memory rather than a block RAM.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  alu_cmd_t               push_data,
    input  logic                   pop,
    output alu_cmd_t               head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    alu_cmd_t mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [LVL_W-1:0] level_reg;
    logic [LVL_W-1:0] level_next;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_reg == LVL_W'(DEPTH));
    assign empty   = (level_reg == '0);
    assign level   = level_reg;
    assign head    = mem[rd_ptr_reg];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // A simultaneous push and pop leaves the occupancy unchanged.
    always_comb begin
        level_next = level_reg;
        case ({do_push, do_pop})
            2'b10:   level_next = level_reg + 1'b1;
            2'b01:   level_next = level_reg - 1'b1;
            default: level_next = level_reg;
        endcase
    end

    // Pointers are PTR_W bits wide and DEPTH is a power of two, so the
    // natural overflow of the increment is the modulo-DEPTH wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            level_reg <= level_next;
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Storage carries no reset; only entries behind the pointers are read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer wrapped around the combinational 4-bit ALU.
// Commands are buffered in a FIFO, issued one at a time on registered
// operand outputs, and the ALU result is captured one cycle later and
// offered with its tag on a valid/ready result port.
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   cmd_valid/cmd_ready                command handshake
//   cmd_mode/cmd_a/cmd_b/cmd_x/cmd_tag command fields
//   alu_mode/alu_a/alu_b/alu_x         registered operands to the ALU
//   alu_out                            combinational ALU result
//   res_valid/res_ready                result handshake
//   res_data/res_tag                   captured result and its tag
//   fifo_level                         current FIFO occupancy
// TAG_W must not exceed alu_pkg::TAG_MAX_W.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [MODE_W-1:0]      cmd_mode,
    input  logic [OPND_W-1:0]      cmd_a,
    input  logic [OPND_W-1:0]      cmd_b,
    input  logic [OPND_W-1:0]      cmd_x,
    input  logic [TAG_W-1:0]       cmd_tag,
    output logic [OPND_W-1:0]      alu_a,
    output logic [OPND_W-1:0]      alu_b,
    output logic [OPND_W-1:0]      alu_x,
    output logic [MODE_W-1:0]      alu_mode,
    input  logic [RES_W-1:0]       alu_out,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [RES_W-1:0]       res_data,
    output logic [TAG_W-1:0]       res_tag,
    output logic [$clog2(DEPTH):0] fifo_level
);

    alu_cmd_t   push_cmd;
    alu_cmd_t   head_cmd;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    logic       capture;
    logic       res_clear;
    seq_state_t state_reg;
    seq_state_t state_next;

    logic [OPND_W-1:0] alu_a_reg;
    logic [OPND_W-1:0] alu_b_reg;
    logic [OPND_W-1:0] alu_x_reg;
    logic [MODE_W-1:0] alu_mode_reg;
    logic [TAG_W-1:0]  tag_hold_reg;
    logic              res_valid_reg;
    logic [RES_W-1:0]  res_data_reg;
    logic [TAG_W-1:0]  res_tag_reg;

    // Tag bits above TAG_W are always zero and are never looked at.
    logic unused_head_tag;
    assign unused_head_tag = ^head_cmd.tag;

    always_comb begin
        push_cmd                 = '0;
        push_cmd.mode            = cmd_mode;
        push_cmd.a               = cmd_a;
        push_cmd.b               = cmd_b;
        push_cmd.x               = cmd_x;
        push_cmd.tag[TAG_W-1:0]  = cmd_tag;
    end

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cmd_valid),
        .push_data (push_cmd),
        .pop       (pop),
        .head      (head_cmd),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Depends only on registered occupancy, never on this cycle's pop.
    assign cmd_ready = !fifo_full;

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        capture    = 1'b0;
        res_clear  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                // Operands have been stable for the whole cycle.
                capture    = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                if (res_ready) begin
                    res_clear = 1'b1;
                    // Chain straight into the next issue to reach one
                    // result every two cycles.
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = ISSUE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            alu_a_reg     <= '0;
            alu_b_reg     <= '0;
            alu_x_reg     <= '0;
            alu_mode_reg  <= '0;
            tag_hold_reg  <= '0;
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
            res_tag_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (pop) begin
                alu_a_reg    <= head_cmd.a;
                alu_b_reg    <= head_cmd.b;
                alu_x_reg    <= head_cmd.x;
                alu_mode_reg <= head_cmd.mode;
                tag_hold_reg <= head_cmd.tag[TAG_W-1:0];
            end
            if (capture) begin
                res_valid_reg <= 1'b1;
                res_data_reg  <= alu_out;
                res_tag_reg   <= tag_hold_reg;
            end else if (res_clear) begin
                res_valid_reg <= 1'b0;
            end
        end
    end

    assign alu_a     = alu_a_reg;
    assign alu_b     = alu_b_reg;
    assign alu_x     = alu_x_reg;
    assign alu_mode  = alu_mode_reg;
    assign res_valid = res_valid_reg;
    assign res_data  = res_data_reg;
    assign res_tag   = res_tag_reg;

endmodule
